// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths and arbiter enums.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  // Lines are 16 bytes, so the low nibble of an address is the byte offset.
  localparam lc3b_word LINE_ADDR_MASK = 16'hFFF0;

  function automatic lc3b_word line_align(input lc3b_word addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: picks which L1 owns the L2 port and remembers the last grant
// so that simultaneous requests alternate between the two caches.
module cache_arbiter_control
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_i_req,
  input  logic      i_d_req,
  input  logic      i_l2_resp,
  output logic      o_load_req,
  output arb_port_t o_grant_sel,
  output logic      o_serve_i,
  output logic      o_serve_d
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  arb_port_t  r_last_grant;

  // State and last-grant registers; last_grant resets to D so the first tie goes to I.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_D;
    end else begin
      r_state <= w_state_next;
      if (o_load_req) begin
        r_last_grant <= o_grant_sel;
      end
    end
  end

  // Next-state and grant decision; grants only happen from IDLE, so there is
  // always at least one IDLE cycle between consecutive services.
  always_comb begin
    w_state_next = r_state;
    o_load_req   = 1'b0;
    o_grant_sel  = PORT_I;
    unique case (r_state)
      IDLE: begin
        if (i_i_req || i_d_req) begin
          o_load_req = 1'b1;
          if (i_i_req && i_d_req) begin
            o_grant_sel = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
          end else if (i_i_req) begin
            o_grant_sel = PORT_I;
          end else begin
            o_grant_sel = PORT_D;
          end
          w_state_next = (o_grant_sel == PORT_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        if (i_l2_resp) begin
          w_state_next = IDLE;
        end
      end
      SERVE_D: begin
        if (i_l2_resp) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_serve_i = (r_state == SERVE_I);
  assign o_serve_d = (r_state == SERVE_D);

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer: o_f = i_sel ? i_b : i_a.
module mux2 #(
  parameter int WIDTH = 16
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_f
);

  // Plain selection, no state.
  always_comb begin
    o_f = i_sel ? i_b : i_a;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port arbiter between the split L1 caches and the unified L2. Holds the
// granted request in registers and steers the L2 response to its owner only.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_read,
  input  lc3b_word i_address,
  output lc3b_line i_rdata,
  output logic     i_resp,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output lc3b_line d_rdata,
  output logic     d_resp,
  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_line l2_wdata,
  input  lc3b_line l2_rdata,
  input  logic     l2_resp
);

  logic      w_load_req;
  arb_port_t w_grant_sel;
  logic      w_serve_i;
  logic      w_serve_d;
  logic      w_sel_d;
  lc3b_word  w_addr_sel;
  lc3b_line  w_wdata_sel;
  logic      w_write_sel;

  lc3b_word  r_address;
  lc3b_line  r_wdata;
  logic      r_write;

  cache_arbiter_control u_control (
    .clk         (clk),
    .reset       (reset),
    .i_i_req     (i_read),
    .i_d_req     (d_read | d_write),
    .i_l2_resp   (l2_resp),
    .o_load_req  (w_load_req),
    .o_grant_sel (w_grant_sel),
    .o_serve_i   (w_serve_i),
    .o_serve_d   (w_serve_d)
  );

  assign w_sel_d = (w_grant_sel == PORT_D);

  mux2 #(.WIDTH(16)) u_addr_mux (
    .i_sel (w_sel_d),
    .i_a   (i_address),
    .i_b   (d_address),
    .o_f   (w_addr_sel)
  );

  // The I-cache never writes, so its grant latches an all-zero line.
  mux2 #(.WIDTH(128)) u_wdata_mux (
    .i_sel (w_sel_d),
    .i_a   ('0),
    .i_b   (d_wdata),
    .o_f   (w_wdata_sel)
  );

  // An illegal d_read+d_write pair is treated as a writeback.
  assign w_write_sel = w_sel_d & d_write;

  // Request registers: captured once at grant, frozen for the whole service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
    end else if (w_load_req) begin
      r_address <= line_align(w_addr_sel);
      r_wdata   <= w_wdata_sel;
      r_write   <= w_write_sel;
    end
  end

  // L2 request side driven purely from registered state; quiet outside service.
  always_comb begin
    l2_read    = w_serve_i | (w_serve_d & ~r_write);
    l2_write   = w_serve_d & r_write;
    l2_address = (w_serve_i | w_serve_d) ? r_address : '0;
    l2_wdata   = w_serve_d ? r_wdata : '0;
  end

  // Response steering: combinational from l2_resp, only to the port being served.
  always_comb begin
    i_resp  = w_serve_i & l2_resp;
    d_resp  = w_serve_d & l2_resp;
    i_rdata = i_resp ? l2_rdata : '0;
    d_rdata = d_resp ? l2_rdata : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a transaction-level owner model is
// compared against every output on each falling edge, and directed scenarios
// pin literal values (addresses, data, grant order).
module tb_cache_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     i_read;
  lc3b_word i_address;
  lc3b_line i_rdata;
  logic     i_resp;
  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  lc3b_line d_rdata;
  logic     d_resp;
  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_line l2_wdata;
  lc3b_line l2_rdata;
  logic     l2_resp;

  int vectors     = 0;
  int miscompares = 0;
  int i_pulses    = 0;
  int d_pulses    = 0;
  bit cmp_en      = 1'b0;

  cache_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: who owns L2 (0 none, 1 I, 2 D) and what was captured.
  int       m_owner;
  int       m_last;
  lc3b_word m_addr;
  lc3b_line m_wdata;
  bit       m_write;

  always @(posedge clk or posedge reset) begin : model
    int pick;
    if (reset) begin
      m_owner <= 0;
      m_last  <= 2;
      m_addr  <= '0;
      m_wdata <= '0;
      m_write <= 1'b0;
    end else if (m_owner == 0) begin
      pick = 0;
      if (i_read && (d_read || d_write)) pick = (m_last == 1) ? 2 : 1;
      else if (i_read)                   pick = 1;
      else if (d_read || d_write)        pick = 2;
      if (pick != 0) begin
        m_owner <= pick;
        m_last  <= pick;
        m_addr  <= ((pick == 1) ? i_address : d_address) & 16'hFFF0;
        m_wdata <= (pick == 2) ? d_wdata : '0;
        m_write <= (pick == 2) && d_write;
      end
    end else if (l2_resp) begin
      m_owner <= 0;
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin : compare
    logic e_i_resp, e_d_resp;
    assert (!(d_read && d_write)) else $error("illegal: d_read and d_write both asserted");
    if (i_resp) i_pulses++;
    if (d_resp) d_pulses++;
    if (cmp_en) begin
      e_i_resp = (m_owner == 1) && l2_resp;
      e_d_resp = (m_owner == 2) && l2_resp;
      check("l2_read",    l2_read,    (m_owner == 1) || (m_owner == 2 && !m_write));
      check("l2_write",   l2_write,   (m_owner == 2) && m_write);
      check("l2_address", l2_address, (m_owner != 0) ? m_addr : 16'h0);
      check("l2_wdata",   l2_wdata,   (m_owner == 2) ? m_wdata : 128'h0);
      check("i_resp",     i_resp,     e_i_resp);
      check("d_resp",     d_resp,     e_d_resp);
      check("i_rdata",    i_rdata,    e_i_resp ? l2_rdata : 128'h0);
      check("d_rdata",    d_rdata,    e_d_resp ? l2_rdata : 128'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Act as L2: wait (bounded) for a request, respond after lat cycles, report who got it.
  task automatic l2_txn(input int lat, input lc3b_line data, output int who, output lc3b_line got);
    int n;
    n = 0;
    who = 0;
    got = '0;
    while (!(l2_read || l2_write) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL l2_req_timeout: got no L2 request in 20 cycles, required one");
      return;
    end
    repeat (lat) tick();
    l2_rdata = data;
    l2_resp  = 1'b1;
    #1;
    if (i_resp) begin
      who = 1;
      got = i_rdata;
    end else if (d_resp) begin
      who = 2;
      got = d_rdata;
    end
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
  endtask

  lc3b_line a5_line = {16{8'hA5}};
  lc3b_line wb_line = 128'h0123456789ABCDEF0123456789ABCDEF;
  int       who;
  lc3b_line got;
  int       order [8];
  int       exp_order [8];
  int       i_before;

  initial begin
    reset = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    exp_order = '{1, 2, 1, 2, 1, 2, 1, 2};
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    tick(); tick();
    check("reset_l2_read",    l2_read,    1'b0);
    check("reset_l2_address", l2_address, 16'h0);
    check("reset_l2_wdata",   l2_wdata,   128'h0);
    check("reset_i_resp",     i_resp,     1'b0);
    reset = 1'b0;
    tick();

    // Single I read.
    i_read = 1'b1; i_address = 16'h1234;
    tick();
    check("iread_l2_read",    l2_read,    1'b1);
    check("iread_l2_write",   l2_write,   1'b0);
    check("iread_l2_address", l2_address, 16'h1230);
    l2_txn(3, a5_line, who, got);
    i_read = 1'b0;
    check("iread_who",   who, 1);
    check("iread_rdata", got, a5_line);
    tick(); tick();
    check("iread_i_pulses", i_pulses, 1);
    check("iread_d_pulses", d_pulses, 0);

    // D writeback.
    d_write = 1'b1; d_address = 16'h8000; d_wdata = wb_line;
    tick();
    check("dwb_l2_write",   l2_write,   1'b1);
    check("dwb_l2_read",    l2_read,    1'b0);
    check("dwb_l2_address", l2_address, 16'h8000);
    check("dwb_l2_wdata",   l2_wdata,   wb_line);
    l2_txn(2, '0, who, got);
    d_write = 1'b0; d_wdata = '0;
    check("dwb_who", who, 2);
    tick();

    // Four simultaneous pairs; the loser is served alone next, so each pair starts with I.
    for (int p = 0; p < 4; p++) begin
      i_read = 1'b1; i_address = 16'h0010;
      d_read = 1'b1; d_address = 16'h0020;
      tick();
      for (int k = 0; k < 2; k++) begin
        l2_txn(1, {8{p[15:0]}}, who, got);
        order[2*p+k] = who;
        if (who == 1) i_read = 1'b0;
        else if (who == 2) d_read = 1'b0;
        else begin i_read = 1'b0; d_read = 1'b0; end
      end
      tick();
    end
    for (int k = 0; k < 8; k++) check("pair_order", order[k], exp_order[k]);

    // Tie after an I grant goes to D; D re-requests, I waits and is next.
    i_read = 1'b1; i_address = 16'h0100;
    tick();
    l2_txn(1, a5_line, who, got);
    i_read = 1'b0;
    check("solo_i_who", who, 1);
    tick();
    i_read = 1'b1; i_address = 16'h0110;
    d_read = 1'b1; d_address = 16'h0200;
    tick();
    check("tie_d_first_addr", l2_address, 16'h0200);
    check("tie_d_first_read", l2_read,    1'b1);
    l2_txn(2, wb_line, who, got);
    check("tie_d_who", who, 2);
    d_address = 16'h0300;
    check("gap_l2_read",  l2_read,  1'b0);
    check("gap_l2_write", l2_write, 1'b0);
    tick();
    check("b2b_i_addr", l2_address, 16'h0110);
    l2_txn(1, a5_line, who, got);
    i_read = 1'b0;
    check("b2b_i_who", who, 1);
    tick();
    check("b2b_d_addr", l2_address, 16'h0300);
    l2_txn(1, a5_line, who, got);
    d_read = 1'b0;
    check("b2b_d_who", who, 2);
    tick();

    // Misbehaving I-cache changes its address mid-service.
    i_read = 1'b1; i_address = 16'h0A50;
    tick();
    i_address = 16'hFFF0;
    tick();
    check("midchg_l2_address", l2_address, 16'h0A50);
    i_before = i_pulses;
    l2_txn(1, a5_line, who, got);
    i_read = 1'b0;
    check("midchg_who", who, 1);
    tick();
    check("midchg_i_pulses", i_pulses - i_before, 1);

    // Reset while D is being served and L2 has not answered.
    d_read = 1'b1; d_address = 16'h4440;
    tick();
    check("rst_pre_l2_read", l2_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_l2_read",    l2_read,    1'b0);
    check("rst_l2_address", l2_address, 16'h0);
    d_read = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    l2_rdata = {8{16'hBEEF}};
    l2_resp  = 1'b1;
    #1;
    check("rst_late_d_resp",  d_resp,  1'b0);
    check("rst_late_i_resp",  i_resp,  1'b0);
    check("rst_late_d_rdata", d_rdata, 128'h0);
    tick();
    l2_resp = 1'b0; l2_rdata = '0;
    tick(); tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
